conv_layer_param: RTL
=====================

CONV_LAYER_PARAM -- requirements
Module: conv_layer_param

Interface
REQ-001 SHALL have parameter PIX_W, default 4, meaning image pixel width (unsigned).
REQ-002 SHALL have parameter WGT_W, default 4, meaning filter weight width (two's complement).
REQ-003 SHALL have parameter K, default 3, meaning kernel side; one window is K*K taps.
REQ-004 SHALL have parameter DEPTH, default 8, meaning result FIFO depth in entries.
REQ-005 SHALL have parameter RELU, default 0, meaning 1 clamps negative window sums to 0.
REQ-006 SHALL derive localparam ACC_W = PIX_W+WGT_W+1+clog2(K*K), 13 at defaults.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst  in  1  reset, synchronous and active-high.
REQ-009 Start  in  1  qualifies one Image/Filter pair this cycle.
REQ-010 Image  in  PIX_W  pixel, unsigned.
REQ-011 Filter  in  WGT_W  weight, signed.
REQ-012 Clear  in  1  aborts the partial window.
REQ-013 ReadEn  in  1  pop request on the result FIFO.
REQ-014 ConvResult  out  ACC_W  signed popped result, registered.
REQ-015 ResultValid  out  1  ConvResult updated this cycle.
REQ-016 Full / Empty  out  1 each  FIFO status.
REQ-017 Count  out  clog2(DEPTH+1)  stored entries.
REQ-018 Overflow  out  1  sticky; a completed window was dropped.

Function
REQ-019 SHALL hold a tap counter (0..K*K-1) and a signed ACC_W accumulator.
REQ-020 On Start=1, SHALL form product = zero-extended Image * sign-extended Filter at ACC_W bits.
REQ-021 Accumulator update on Start=1: tap 0 loads the product; any other tap adds the product; tap increments.
REQ-022 On Start=1 at tap K*K-1: SHALL push acc+product (0 if RELU=1 and negative) to the FIFO; tap wraps to 0; entry visible in Count the next cycle.
REQ-023 Start=0: tap and accumulator hold, so pairs may be separated by idle cycles.
REQ-024 Clear=1: tap<=0, accumulator<=0, and any same-cycle Start pair is discarded; FIFO is untouched.
REQ-025 A push while Full with no pop: result dropped, Overflow<=1, Count unchanged.
REQ-026 A push and a pop in the same cycle while Full: both occur, Overflow is not set, Count stays DEPTH.
REQ-027 ReadEn=1 with Count>0: ConvResult<=head (FIFO order), ResultValid=1 for one cycle, Count decrements unless a push coincides.
REQ-028 ReadEn=1 while Empty: ResultValid=0, ConvResult holds; no read-through of a same-cycle push.
REQ-029 Full = (Count==DEPTH) and Empty = (Count==0), both combinational from Count.
REQ-030 Pointers SHALL wrap modulo DEPTH; DEPTH need not be a power of two.
REQ-031 No internal overflow is possible: ACC_W bounds K*K worst-case products.

Reset
REQ-032 rst=1 at a clock edge: tap=0, accumulator=0, FIFO pointers=0, Count=0, ConvResult=0, ResultValid=0, Overflow=0, Empty=1, Full=0.
REQ-033 rst SHALL take priority over Start, Clear and ReadEn, and SHALL discard any partial window or stored results.

Verification (defaults unless stated)
REQ-034 Nine pairs, pixels 1,2,3,2,3,4,3,4,5 and weights 1,2,3,-3,-2,-1,1,2,3, then ReadEn for one cycle -> Count 0->1, then ConvResult=24 with ResultValid=1 for one cycle, Empty=1.
REQ-035 The same nine pairs with idle Start=0 cycles inserted -> ConvResult=24; pixels all 15 with weights all -8 -> -1080 (RELU=0) and 0 (RELU=1).
REQ-036 Nine windows with no reads -> Full=1, Count=8, Overflow=1; eight pops return windows 1..8 in order; a ninth pop gives ResultValid=0.
REQ-037 While Full, the last pair of a window coincides with ReadEn -> Overflow stays 0, Count=8, the new result is at the tail.
REQ-038 Four pairs, Clear, then the REQ-034 window -> 24; rst with two results stored and three taps pending -> all REQ-032 values next cycle.

Source files
------------

// File: rtl/conv_layer_param.sv
// conv_layer_param
//   Streaming K x K convolution window accumulator with a result FIFO.
//   Each Start cycle supplies one unsigned pixel / signed weight pair. After
//   K*K pairs the window sum, with an optional ReLU clamp, is pushed into a
//   DEPTH-entry FIFO. ReadEn pops the FIFO into a registered output.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   Start        qualifies Image/Filter this cycle
//   Image        unsigned pixel (PIX_W)
//   Filter       signed weight (WGT_W)
//   Clear        aborts the partial window (FIFO untouched)
//   ReadEn       pop request
//   ConvResult   signed popped result (ACC_W), registered
//   ResultValid  ConvResult updated this cycle
//   Full/Empty   FIFO status, combinational from Count
//   Count        stored entries
//   Overflow     sticky: a completed window was dropped
module conv_layer_param #(
  parameter int PIX_W = 4,
  parameter int WGT_W = 4,
  parameter int K     = 3,
  parameter int DEPTH = 8,
  parameter int RELU  = 0,
  localparam int ACC_W = PIX_W + WGT_W + 1 + $clog2(K * K),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Start,
  input  logic [PIX_W-1:0]        Image,
  input  logic [WGT_W-1:0]        Filter,
  input  logic                    Clear,
  input  logic                    ReadEn,
  output logic signed [ACC_W-1:0] ConvResult,
  output logic                    ResultValid,
  output logic                    Full,
  output logic                    Empty,
  output logic [CNT_W-1:0]        Count,
  output logic                    Overflow
);

  localparam int TAPS  = K * K;
  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  function automatic logic signed [ACC_W-1:0] relu_clamp(input logic signed [ACC_W-1:0] x);
    if ((RELU != 0) && (x < 0)) return '0;
    return x;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    // Explicit wrap so a non power-of-two DEPTH still cycles correctly.
    if (p == LAST_PTR) return '0;
    return p + PTR_W'(1);
  endfunction

  logic [TAP_W-1:0]        tap_p0;
  logic signed [ACC_W-1:0] acc_p0;
  logic signed [ACC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;

  logic signed [ACC_W-1:0] pix_ext, wgt_ext, prod, sum;
  logic                    take, win_done, pop, do_push;

  // ---- stage p0: multiply-accumulate (combinational feed into acc_p0) ----
  always_comb begin
    pix_ext  = {{(ACC_W-PIX_W){1'b0}}, Image};
    wgt_ext  = {{(ACC_W-WGT_W){Filter[WGT_W-1]}}, Filter};
    prod     = pix_ext * wgt_ext;
    // Tap 0 starts a fresh window, so the stale accumulator is ignored.
    sum      = ((tap_p0 == '0) ? '0 : acc_p0) + prod;
    take     = Start && !Clear;
    win_done = take && (tap_p0 == LAST_TAP);
    pop      = ReadEn && (Count != '0);
    // A full FIFO still accepts a push when the same cycle frees a slot.
    do_push  = win_done && ((Count != CNT_W'(DEPTH)) || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_p0 <= '0;
      acc_p0 <= '0;
    end else if (Clear) begin
      tap_p0 <= '0;
      acc_p0 <= '0;
    end else if (take) begin
      acc_p0 <= sum;
      tap_p0 <= win_done ? '0 : tap_p0 + TAP_W'(1);
    end
  end

  // ---- stage p1: result FIFO and registered output ----
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= relu_clamp(sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      Count       <= '0;
      ConvResult  <= '0;
      ResultValid <= 1'b0;
      Overflow    <= 1'b0;
    end else begin
      ResultValid <= pop;
      if (pop) begin
        // Reads the pre-write contents, so a same-slot push never reads through.
        ConvResult <= mem[rd_ptr];
        rd_ptr     <= ptr_next(rd_ptr);
      end
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (win_done && !do_push) Overflow <= 1'b1;
      case ({do_push, pop})
        2'b10:   Count <= Count + CNT_W'(1);
        2'b01:   Count <= Count - CNT_W'(1);
        default: Count <= Count;
      endcase
    end
  end

  assign Full  = (Count == CNT_W'(DEPTH));
  assign Empty = (Count == '0);

endmodule
